// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared definitions for the FM_FFT frame sequencer.
//   PTS_W      - width of the FFT points field
//   state_t    - sequencer FSM encoding
//   npts_legal - true for the frame sizes the FFT core supports (8/16/32/64)
package fft_ctrl_pkg;

  localparam int PTS_W = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic logic npts_legal(input logic [PTS_W-1:0] n);
    return (n == PTS_W'(8))  || (n == PTS_W'(16)) ||
           (n == PTS_W'(32)) || (n == PTS_W'(64));
  endfunction

endpackage

// File: rtl/fft_pts_fifo.sv
// fft_pts_fifo: small FIFO of frame sizes, one entry per frame that has
// started on the sink but not yet finished on the source.
//   clk, rst - clock, synchronous active-high reset
//   push/din - enqueue a frame size (ignored when full)
//   pop      - drop the head entry (ignored when empty)
//   head     - oldest entry (stale when empty)
module fft_pts_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: cuts the demodulator I/Q stream into N-point frames for
// the FFT sink, caps frames in flight, and snoops the FFT source to count
// finished frames and flag framing errors.
//   clk_clk, reset_reset       - clock, synchronous active-high reset
//   enable, cfg_npts, cfg_inverse - frame start control, sampled in IDLE
//   smp_*                      - input sample stream (valid/ready)
//   fft_sink_*                 - combinational sink path to the FFT core
//   fft_source_*               - snooped FFT output handshake
//   frames_sent/frames_done/inflight/cfg_err/src_err - registered status
module fft_frame_ctrl #(
  parameter int DW           = 18,
  parameter int PTS_W        = 7,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 16,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  enable,
  input  logic [PTS_W-1:0]      cfg_npts,
  input  logic                  cfg_inverse,
  input  logic                  smp_valid,
  output logic                  smp_ready,
  input  logic [2*DW-1:0]       smp_data,
  output logic                  fft_sink_valid,
  input  logic                  fft_sink_ready,
  output logic [1:0]            fft_sink_error,
  output logic                  fft_sink_startofpacket,
  output logic                  fft_sink_endofpacket,
  output logic [2*DW+PTS_W:0]   fft_sink_data,
  input  logic                  fft_source_valid,
  input  logic                  fft_source_ready,
  input  logic [1:0]            fft_source_error,
  input  logic                  fft_source_startofpacket,
  input  logic                  fft_source_endofpacket,
  output logic [CNT_W-1:0]      frames_sent,
  output logic [CNT_W-1:0]      frames_done,
  output logic [IW-1:0]         inflight,
  output logic                  cfg_err,
  output logic                  src_err
);
  import fft_ctrl_pkg::*;

  localparam logic [IW-1:0] MAX_IF = IW'(MAX_INFLIGHT);

  state_t           state, state_nxt;
  logic [PTS_W-1:0] npts_q, in_cnt, out_cnt, head_npts, head_last;
  logic             inv_q;
  logic             start, cfg_bad, sink_beat, sink_eop_beat;
  logic             src_beat, src_eop, src_dec, src_viol;

  assign fft_sink_error = 2'b00;

  // ---------------- sink sequencer ----------------
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt              = state;
    start                  = 1'b0;
    cfg_bad                = 1'b0;
    fft_sink_valid         = 1'b0;
    smp_ready              = 1'b0;
    fft_sink_startofpacket = 1'b0;
    fft_sink_endofpacket   = 1'b0;
    fft_sink_data          = '0;
    case (state)
      IDLE: begin
        if (enable) begin
          if (!npts_legal(cfg_npts)) begin
            cfg_bad = 1'b1;
          end else if (inflight < MAX_IF) begin
            start     = 1'b1;
            state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        fft_sink_valid         = smp_valid;
        smp_ready              = fft_sink_ready;
        fft_sink_data          = {smp_data, npts_q, inv_q};
        fft_sink_startofpacket = (in_cnt == '0);
        fft_sink_endofpacket   = (in_cnt == npts_q - 1'b1);
        // enable is not looked at here: a started frame always completes
        if (smp_valid && fft_sink_ready && fft_sink_endofpacket)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sink_beat     = fft_sink_valid && fft_sink_ready;
  assign sink_eop_beat = sink_beat && fft_sink_endofpacket;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      npts_q <= '0;
      inv_q  <= 1'b0;
      in_cnt <= '0;
    end else if (start) begin
      npts_q <= cfg_npts;
      inv_q  <= cfg_inverse;
      in_cnt <= '0;
    end else if (sink_beat) begin
      in_cnt <= fft_sink_endofpacket ? '0 : in_cnt + 1'b1;
    end
  end

  // Frame sizes are queued at frame start so the source monitor always
  // knows the length of the frame it is currently watching.
  fft_pts_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (PTS_W)
  ) u_pts_fifo (
    .clk  (clk_clk),
    .rst  (reset_reset),
    .push (start),
    .pop  (src_eop),
    .din  (cfg_npts),
    .head (head_npts)
  );

  // ---------------- source monitor ----------------
  assign src_beat  = fft_source_valid && fft_source_ready;
  assign src_eop   = src_beat && fft_source_endofpacket;
  assign src_dec   = src_eop && (inflight != '0);
  assign head_last = head_npts - 1'b1;

  assign src_viol = src_beat && (
      ( fft_source_startofpacket && (out_cnt != '0))      ||
      (!fft_source_startofpacket && (out_cnt == '0))      ||
      ( fft_source_endofpacket   && (out_cnt != head_last)) ||
      (!fft_source_endofpacket   && (out_cnt == head_last)) ||
      (fft_source_error != 2'b00)                         ||
      ( fft_source_endofpacket   && (inflight == '0)));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      frames_sent <= '0;
      frames_done <= '0;
      inflight    <= '0;
      cfg_err     <= 1'b0;
      src_err     <= 1'b0;
      out_cnt     <= '0;
    end else begin
      if (sink_eop_beat) frames_sent <= frames_sent + 1'b1;
      if (src_eop)       frames_done <= frames_done + 1'b1;
      // sink and source EOP together cancel out
      if (sink_eop_beat && !src_dec)      inflight <= inflight + 1'b1;
      else if (!sink_eop_beat && src_dec) inflight <= inflight - 1'b1;
      if (cfg_bad)  cfg_err <= 1'b1;
      if (src_viol) src_err <= 1'b1;
      if (src_beat) out_cnt <= fft_source_endofpacket ? '0 : out_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: a sink scoreboard holds the expected beat
// sequence (data, size, direction, SOP/EOP) pushed as samples are offered;
// a negedge monitor pops and compares every accepted sink beat.
module tb_fft_frame_ctrl;
  localparam int DW  = 18;
  localparam int PW  = 7;
  localparam int SDW = 2*DW + PW + 1;

  logic            clk_clk = 1'b0;
  logic            reset_reset, enable, cfg_inverse, smp_valid, smp_ready;
  logic [PW-1:0]   cfg_npts;
  logic [2*DW-1:0] smp_data;
  logic            fft_sink_valid, fft_sink_ready = 1'b1;
  logic [1:0]      fft_sink_error;
  logic            fft_sink_startofpacket, fft_sink_endofpacket;
  logic [SDW-1:0]  fft_sink_data;
  logic            fft_source_valid, fft_source_ready;
  logic [1:0]      fft_source_error;
  logic            fft_source_startofpacket, fft_source_endofpacket;
  logic [15:0]     frames_sent, frames_done;
  logic [1:0]      inflight;
  logic            cfg_err, src_err;

  fft_frame_ctrl dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable),
    .cfg_npts(cfg_npts), .cfg_inverse(cfg_inverse),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .fft_sink_valid(fft_sink_valid), .fft_sink_ready(fft_sink_ready),
    .fft_sink_error(fft_sink_error),
    .fft_sink_startofpacket(fft_sink_startofpacket),
    .fft_sink_endofpacket(fft_sink_endofpacket), .fft_sink_data(fft_sink_data),
    .fft_source_valid(fft_source_valid), .fft_source_ready(fft_source_ready),
    .fft_source_error(fft_source_error),
    .fft_source_startofpacket(fft_source_startofpacket),
    .fft_source_endofpacket(fft_source_endofpacket),
    .frames_sent(frames_sent), .frames_done(frames_done), .inflight(inflight),
    .cfg_err(cfg_err), .src_err(src_err)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct { logic [SDW-1:0] data; logic sop; logic eop; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   rdy_rand = 0;
  bit   src_with_last = 0;

  always @(posedge clk_clk) begin
    #1;
    fft_sink_ready = rdy_rand ? ($urandom_range(0, 99) < 60) : 1'b1;
  end

  always @(negedge clk_clk) begin
    if (!reset_reset && fft_sink_valid && fft_sink_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sink_beat unexpected beat data=%h sop=%b eop=%b",
                 fft_sink_data, fft_sink_startofpacket, fft_sink_endofpacket);
      end else begin
        e = exp_q.pop_front();
        if ({fft_sink_data, fft_sink_startofpacket, fft_sink_endofpacket} !==
            {e.data, e.sop, e.eop}) begin
          errors++;
          $display("FAIL sink_beat got %h/%b%b exp %h/%b%b", fft_sink_data,
                   fft_sink_startofpacket, fft_sink_endofpacket, e.data, e.sop, e.eop);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_clk); #1;
  endtask

  task automatic do_reset();
    reset_reset = 1; enable = 0; cfg_npts = '0; cfg_inverse = 0;
    smp_valid = 0; smp_data = '0; rdy_rand = 0; src_with_last = 0;
    fft_source_valid = 0; fft_source_ready = 0; fft_source_error = 0;
    fft_source_startofpacket = 0; fft_source_endofpacket = 0;
    exp_q.delete();
    tick(); tick();
    reset_reset = 0;
  endtask

  // Offer beats 0..nbeats-1 of an n-point frame; enable drops after beat 0.
  task automatic send_frame(input int n, input logic inv, input bit gaps, input int nbeats);
    exp_t x;
    int t;
    cfg_npts = PW'(n); cfg_inverse = inv; enable = 1;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        smp_valid = 0;
        repeat ($urandom_range(0, 2)) tick();
      end
      smp_data  = {$urandom, $urandom}; // upper bits truncated to 36
      smp_valid = 1;
      x.data = {smp_data, PW'(n), inv}; x.sop = (k == 0); x.eop = (k == n-1);
      exp_q.push_back(x);
      if (src_with_last && k == n-1) begin
        fft_source_valid = 1; fft_source_ready = 1;
        fft_source_startofpacket = 0; fft_source_endofpacket = 1;
      end
      t = 0;
      do begin @(negedge clk_clk); t++; end while (!smp_ready && t < 300);
      if (!smp_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout beat %0d of N=%0d never accepted", k, n);
        smp_valid = 0; enable = 0;
        return;
      end
      tick();
      fft_source_valid = 0; fft_source_endofpacket = 0;
      if (k == 0) enable = 0;
    end
    smp_valid = 0;
  endtask

  // Source side: n beats, EOP on beat eop_at (-1 = none).
  task automatic src_frame(input int n, input int eop_at);
    for (int k = 0; k < n; k++) begin
      fft_source_valid = 1; fft_source_ready = 1; fft_source_error = 0;
      fft_source_startofpacket = (k == 0); fft_source_endofpacket = (k == eop_at);
      tick();
    end
    fft_source_valid = 0; fft_source_startofpacket = 0; fft_source_endofpacket = 0;
  endtask

  task automatic chk_status(input string nm, input int fs, input int fd, input int inf, input logic se);
    // plain inline comparisons of the four status outputs
    checks++;
    if ({frames_sent, frames_done, inflight, src_err} !== {16'(fs), 16'(fd), 2'(inf), se}) begin
      errors++;
      $display("FAIL %s sent/done/inflight/src_err got %0d/%0d/%0d/%b exp %0d/%0d/%0d/%b",
               nm, frames_sent, frames_done, inflight, src_err, fs, fd, inf, se);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fft_sink_valid, smp_ready, fft_sink_startofpacket, fft_sink_endofpacket,
         fft_sink_data, fft_sink_error, frames_sent, frames_done, inflight, cfg_err, src_err} !== '0) begin
      errors++;
      $display("FAIL reset_state outputs nonzero: valid=%b ready=%b sent=%0d done=%0d inflight=%0d",
               fft_sink_valid, smp_ready, frames_sent, frames_done, inflight);
    end
  endtask

  task automatic test_single_n64();
    do_reset();
    send_frame(64, 0, 0, 64);
    chk_status("n64_sent", 1, 0, 1, 0);
    src_frame(64, 63);
    chk_status("n64_done", 1, 1, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL n64_beats missing %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_inflight_limit();
    bit seen;
    do_reset();
    send_frame(8, 0, 0, 8);
    send_frame(8, 1, 0, 8);
    chk_status("limit_two", 2, 0, 2, 0);
    cfg_npts = 8; enable = 1; smp_valid = 1; smp_data = '1;
    seen = 0;
    repeat (20) begin @(negedge clk_clk); if (smp_ready) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL limit_block smp_ready got 1 exp 0"); end
    tick(); smp_valid = 0;
    src_frame(8, 7);
    send_frame(8, 0, 0, 8);
    chk_status("limit_third", 3, 1, 2, 0);
  endtask

  task automatic test_cfg_err();
    do_reset();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pre got %b exp 0", cfg_err); end
    cfg_npts = 12; enable = 1; smp_valid = 1;
    tick();
    checks++;
    if ({cfg_err, fft_sink_valid} !== 2'b10) begin
      errors++; $display("FAIL cfg_err_bad cfg_err/sink_valid got %b%b exp 10", cfg_err, fft_sink_valid);
    end
    tick();
    checks++;
    if (fft_sink_valid !== 1'b0) begin errors++; $display("FAIL cfg_err_idle sink_valid got 1 exp 0"); end
    enable = 0; smp_valid = 0;
  endtask

  task automatic test_mixed_sizes();
    do_reset();
    send_frame(16, 0, 0, 16);
    send_frame(32, 1, 0, 32);
    src_frame(16, 15);
    src_frame(32, 31);
    chk_status("mixed_ok", 2, 2, 0, 0);
    do_reset();
    send_frame(16, 0, 0, 16);
    src_frame(15, 14);
    chk_status("early_eop", 1, 1, 0, 1);
  endtask

  task automatic test_random_gaps();
    do_reset();
    rdy_rand = 1;
    send_frame(32, 1, 1, 32);
    rdy_rand = 0;
    tick();
    chk_status("gaps_sent", 1, 0, 1, 0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL gaps_beats missing %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(8, 0, 0, 8);
    src_frame(7, -1);
    src_with_last = 1;
    send_frame(16, 0, 0, 16);
    src_with_last = 0;
    chk_status("simul_eop", 2, 1, 1, 0);
    src_frame(16, 15);
    chk_status("simul_after", 2, 2, 0, 0);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_frame(8, 0, 0, 8);
    send_frame(64, 0, 0, 5);
    smp_valid = 1; smp_data = '1; reset_reset = 1;
    tick();
    checks++;
    if ({fft_sink_valid, smp_ready, fft_sink_startofpacket, fft_sink_endofpacket,
         fft_sink_data, frames_sent, inflight} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got valid=%b ready=%b sent=%0d inflight=%0d exp 0",
               fft_sink_valid, smp_ready, frames_sent, inflight);
    end
    reset_reset = 0; smp_valid = 0; exp_q.delete();
    tick();
    checks++;
    if ({fft_sink_valid, smp_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_idle valid/ready got %b%b exp 00", fft_sink_valid, smp_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_n64();
    test_inflight_limit();
    test_cfg_err();
    test_mixed_sizes();
    test_random_gaps();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer and monitor for the FM_FFT streaming core. Takes the continuous 18-bit I/Q sample stream from the FM demodulator, cuts it into N-point frames with SOP/EOP and per-frame size/direction fields on the FFT sink, limits the number of frames in flight, and snoops the FFT source handshake to count completed frames and flag framing errors.

## Interface

Parameters:
- DW, 18, sample component width (real and imag each)
- PTS_W, 7, width of the FFT points field (max N = 64)
- MAX_INFLIGHT, 2, frames accepted by the core but not yet fully emitted
- CNT_W, 16, width of frame counters

Ports (one clock; reset is synchronous and active-high):
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous active-high reset
- enable  in  1  allow new frames to start
- cfg_npts  in  PTS_W  points per frame; legal values 8, 16, 32, 64
- cfg_inverse  in  1  1 = IFFT
- smp_valid  in  1  sample valid
- smp_ready  out  1  sample accepted when valid and ready
- smp_data  in  2*DW  {re, im}
- fft_sink_valid  out  1  to FFT sink
- fft_sink_ready  in  1  from FFT sink
- fft_sink_error  out  2  tied 0
- fft_sink_startofpacket  out  1  first beat of frame
- fft_sink_endofpacket  out  1  last beat of frame
- fft_sink_data  out  2*DW+PTS_W+1  {re, im, npts, inverse}
- fft_source_valid  in  1  snooped
- fft_source_ready  in  1  snooped (driven by downstream)
- fft_source_error  in  2  snooped
- fft_source_startofpacket  in  1  snooped
- fft_source_endofpacket  in  1  snooped
- frames_sent  out  CNT_W  frames fully delivered to sink
- frames_done  out  CNT_W  frames fully emitted by source
- inflight  out  $clog2(MAX_INFLIGHT+1)  current in-flight count
- cfg_err  out  1  sticky: illegal cfg_npts at frame start
- src_err  out  1  sticky: source framing/error violation

## Operation

- FSM states IDLE, STREAM.
- IDLE -> STREAM when enable=1, cfg_npts legal, inflight < MAX_INFLIGHT: latch npts/inverse, beat counter = 0, push npts into point FIFO.
- IDLE with enable=1 and illegal cfg_npts: set cfg_err, stay in IDLE.
- STREAM: fft_sink_valid = smp_valid; smp_ready = fft_sink_ready; data = {smp_data, latched npts, latched inverse}; SOP when count = 0, EOP when count = npts-1. Beat = valid & ready increments count.
- EOP beat: frames_sent+1, inflight+1, -> IDLE. Outside STREAM: sink_valid = 0, smp_ready = 0.
- enable dropping mid-frame does not truncate; frame completes.
- Monitor: source beat = source_valid & source_ready. Output beat counter compared to FIFO head npts. src_err set if: SOP at count ≠ 0; non-SOP beat at count = 0; EOP at count ≠ npts-1; missing EOP at count = npts-1; error ≠ 0 on any beat; EOP with inflight = 0.
- Source EOP: frames_done+1, inflight-1 (floor 0), pop FIFO, out count = 0.
- Simultaneous sink EOP and source EOP: inflight unchanged, both counters increment, FIFO push and pop both occur.
- Counters wrap modulo 2^CNT_W. Sticky flags clear only on reset.

## Timing

- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0.
- Sink path combinational (0-cycle latency sample -> sink).
- One bubble cycle in IDLE between frames (min N+1 cycles per frame).
- Status outputs registered; update the cycle after the causing beat.
- Reset mid-frame aborts the frame without EOP; the FFT core must be reset in the same cycle by the system.

## Structure

- Package fft_ctrl_pkg: PTS_W, legal-npts check function, state enum.
- Sub-module fft_pts_fifo: depth MAX_INFLIGHT, width PTS_W, push/pop/head, same clock/reset.

## Test plan

- N=64, continuous samples, ready=1 -> SOP on beat 0, EOP on beat 63, frames_sent=1, inflight=1; source emits 64 beats -> frames_done=1, inflight=0, src_err=0.
- MAX_INFLIGHT=2, source idle, 3 frames of N=8 offered -> frames_sent=2, smp_ready stays 0 after beat 15 until first source EOP.
- cfg_npts=12 with enable=1 -> cfg_err=1 next cycle, no sink_valid.
- Frame N=16, then N=32 queued; source EOP at beat 15 then beat 31 -> src_err=0; EOP at beat 14 -> src_err=1.
- Random sink_ready/smp_valid gaps on N=32 -> exactly 32 beats, data order preserved; sink EOP and source EOP same cycle -> inflight unchanged.
- reset_reset asserted at beat 5 of N=64 -> next cycle all outputs 0, FSM IDLE.
